// File: rtl/led_step_gen.sv
// Tempo-controlled step generator for an LED chaser.
// Two debounced push-buttons raise/lower an 8-level tempo; a 32-bit period
// counter emits a one-cycle step_tick every STEP_BASE*(8-tempo_idx) cycles
// while play_en is high, and beat counts the ticks modulo 8.
module led_step_gen #(
    parameter int unsigned STEP_BASE       = 1_562_500,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_faster,
    input  logic       btn_slower,
    input  logic       play_en,
    output logic       step_tick,
    output logic [2:0] tempo_idx,
    output logic [2:0] beat
);

    localparam int unsigned    DbW    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

    // Index 0 is the faster button, index 1 the slower button.
    logic [1:0]     btn_raw;
    logic [1:0]     sync1_q, sync2_q;
    logic [1:0]     stable_q, stable_d;
    logic [1:0]     prev_q;
    logic [DbW-1:0] db_cnt_q [2];
    logic [DbW-1:0] db_cnt_d [2];

    logic           faster_ev, slower_ev;
    logic [2:0]     tempo_q, tempo_d;
    logic           tempo_chg;

    logic [31:0]    period;
    logic [31:0]    cnt_q, cnt_d;
    logic           tick_q, tick_d;
    logic [2:0]     beat_q, beat_d;

    assign btn_raw = {btn_slower, btn_faster};

    // Two-flop synchronizers for the asynchronous buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: toggle the stable state once the input has differed for
    // DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = stable_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state plus a delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q    <= '0;
            prev_q      <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            stable_q    <= stable_d;
            prev_q      <= stable_q;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
        end
    end

    // Press events fire only on the 0->1 debounced transition.
    assign faster_ev = stable_q[0] & ~prev_q[0];
    assign slower_ev = stable_q[1] & ~prev_q[1];

    // Saturating tempo update; simultaneous presses cancel out.
    always_comb begin
        tempo_d = tempo_q;
        if (faster_ev && !slower_ev && (tempo_q != 3'd7)) begin
            tempo_d = tempo_q + 3'd1;
        end else if (slower_ev && !faster_ev && (tempo_q != 3'd0)) begin
            tempo_d = tempo_q - 3'd1;
        end
        tempo_chg = (tempo_d != tempo_q);
    end

    // Width-4 subtraction keeps 8-0 representable before widening.
    assign period = 32'(STEP_BASE) * 32'(4'd8 - {1'b0, tempo_q});

    // Period counter: a tempo change restarts the count and swallows any tick
    // due in that cycle; play_en low parks the counter at 0.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        beat_d = beat_q;
        if (tempo_chg || !play_en) begin
            cnt_d = '0;
        end else if (cnt_q == period - 32'd1) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            beat_d = beat_q + 3'd1;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Tempo, counter, tick and beat registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tempo_q <= 3'd3;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            beat_q  <= '0;
        end else begin
            tempo_q <= tempo_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            beat_q  <= beat_d;
        end
    end

    assign step_tick = tick_q;
    assign tempo_idx = tempo_q;
    assign beat      = beat_q;

endmodule

// File: tb/tb_led_step_gen.sv
// Bench for led_step_gen: directed scenarios followed by random button/play
// activity, checked against a behavioural model through an expected-tick queue.
module tb_led_step_gen;

    localparam int unsigned SB = 4;
    localparam int unsigned DB = 3;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       btn_faster = 1'b0;
    logic       btn_slower = 1'b0;
    logic       play_en    = 1'b0;
    logic       step_tick;
    logic [2:0] tempo_idx;
    logic [2:0] beat;

    led_step_gen #(
        .STEP_BASE      (SB),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_faster(btn_faster),
        .btn_slower(btn_slower),
        .play_en   (play_en),
        .step_tick (step_tick),
        .tempo_idx (tempo_idx),
        .beat      (beat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;   // number of rising edges seen
    int dut_ticks = 0;
    int last_tick = -1;
    int prev_tick = -1;

    // Reference model state
    int m_tempo, m_phase, m_beat;
    bit m_hist [2][2];  // raw button seen one and two edges ago
    bit m_stab [2];
    bit m_prev [2];
    int m_run  [2];
    int exp_cyc[$];
    int exp_beat[$];

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model_reset();
        m_tempo = 3;
        m_phase = 0;
        m_beat  = 0;
        for (int i = 0; i < 2; i++) begin
            m_hist[i][0] = 1'b0;
            m_hist[i][1] = 1'b0;
            m_stab[i]    = 1'b0;
            m_prev[i]    = 1'b0;
            m_run[i]     = 0;
        end
        exp_cyc.delete();
        exp_beat.delete();
    endtask

    // Advance the model by one rising edge using the inputs held across it.
    task automatic model_step();
        bit ev_f, ev_s, s2;
        bit raw [2];
        int nt, p;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        raw[0] = btn_faster;
        raw[1] = btn_slower;
        ev_f = m_stab[0] && !m_prev[0];
        ev_s = m_stab[1] && !m_prev[1];
        nt = m_tempo;
        if (ev_f && !ev_s) nt = (m_tempo < 7) ? m_tempo + 1 : 7;
        else if (ev_s && !ev_f) nt = (m_tempo > 0) ? m_tempo - 1 : 0;
        p = SB * (8 - m_tempo);
        if (nt != m_tempo) begin
            m_tempo = nt;
            m_phase = 0;
        end else if (!play_en) begin
            m_phase = 0;
        end else if (m_phase == p - 1) begin
            m_phase = 0;
            m_beat  = (m_beat + 1) % 8;
            exp_cyc.push_back(cyc);
            exp_beat.push_back(m_beat);
        end else begin
            m_phase++;
        end
        for (int i = 0; i < 2; i++) begin
            s2 = m_hist[i][1];
            m_prev[i] = m_stab[i];
            if (s2 != m_stab[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_stab[i] = !m_stab[i];
                    m_run[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            m_hist[i][1] = m_hist[i][0];
            m_hist[i][0] = raw[i];
        end
    endtask

    // Monitor: compares visible outputs and pops the expected-tick queue.
    initial begin
        forever begin
            @(negedge clk);
            check("tempo_idx", int'(tempo_idx), m_tempo);
            check("beat", int'(beat), m_beat);
            if (exp_cyc.size() > 0 && exp_cyc[0] == cyc) begin
                check("tick_present", int'(step_tick), 1);
                check("tick_beat", int'(beat), exp_beat[0]);
                void'(exp_cyc.pop_front());
                void'(exp_beat.pop_front());
            end else if (step_tick) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_tick: got 1, expected 0 (cycle %0d)", cyc);
            end
            if (step_tick) begin
                dut_ticks++;
                prev_tick = last_tick;
                last_tick = cyc;
            end
        end
    end

    // One clock: model follows the edge, returns just after the falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic press(input bit f, input bit s, input int hold);
        btn_faster = f;
        btn_slower = s;
        cycles(hold);
        btn_faster = 1'b0;
        btn_slower = 1'b0;
        cycles(8);
    endtask

    task automatic wait_ticks(input int n, input int budget);
        int start;
        int k;
        start = dut_ticks;
        k = 0;
        while ((dut_ticks - start) < n && k < budget) begin
            step();
            k++;
        end
        check("tick_timeout", dut_ticks - start, n);
    endtask

    initial begin
        int k;
        int b;
        int t0;
        model_reset();
        step();
        step();
        check("rst_tick", int'(step_tick), 0);
        check("rst_tempo", int'(tempo_idx), 3);
        check("rst_beat", int'(beat), 0);

        // Default tempo: P=20, beat wraps after 8 ticks
        rst_n = 1'b1;
        step();
        play_en = 1'b1;
        k = cyc + 1;
        wait_ticks(1, 40);
        check("first_tick_cycle", last_tick, k + 19);
        wait_ticks(7, 200);
        check("beat_wrap", int'(beat), 0);
        check("period_20", last_tick - prev_tick, 20);

        // Short glitch rejected, long press accepted
        press(1'b1, 1'b0, 2);
        check("glitch_no_change", int'(tempo_idx), 3);
        press(1'b1, 1'b0, 6);
        check("tempo_up_4", int'(tempo_idx), 4);
        wait_ticks(2, 60);
        check("period_16", last_tick - prev_tick, 16);

        // Saturate at 7 and press once more
        repeat (4) press(1'b1, 1'b0, 6);
        check("tempo_sat_7", int'(tempo_idx), 7);
        press(1'b1, 1'b0, 6);
        check("tempo_still_7", int'(tempo_idx), 7);
        wait_ticks(2, 20);
        check("period_4", last_tick - prev_tick, 4);

        // Slower, then both together
        press(1'b0, 1'b1, 6);
        check("tempo_down_6", int'(tempo_idx), 6);
        press(1'b1, 1'b1, 6);
        check("both_no_change", int'(tempo_idx), 6);

        // play_en dropped mid-period
        wait_ticks(1, 20);
        cycles(3);
        b = int'(beat);
        t0 = dut_ticks;
        play_en = 1'b0;
        cycles(15);
        check("pause_beat_held", int'(beat), b);
        check("pause_no_ticks", dut_ticks, t0);
        play_en = 1'b1;
        k = cyc + 1;
        wait_ticks(1, 20);
        check("resume_full_period", last_tick, k + 7);

        // Reset mid-period at tempo 6
        cycles(3);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_tick", int'(step_tick), 0);
        check("async_rst_tempo", int'(tempo_idx), 3);
        check("async_rst_beat", int'(beat), 0);
        step();
        step();
        rst_n = 1'b1;
        k = cyc + 1;
        wait_ticks(1, 40);
        check("post_rst_tick", last_tick, k + 19);

        // Button held through reset release yields one press
        rst_n = 1'b0;
        model_reset();
        btn_faster = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        cycles(12);
        btn_faster = 1'b0;
        cycles(10);
        check("held_btn_one_press", int'(tempo_idx), 4);

        // Random activity
        for (int s = 0; s < 70; s++) begin
            btn_faster = 1'($urandom_range(0, 1));
            btn_slower = 1'($urandom_range(0, 1));
            play_en    = ($urandom_range(0, 7) != 0);
            cycles($urandom_range(1, 8));
        end
        btn_faster = 1'b0;
        btn_slower = 1'b0;
        cycles(10);
        check("exp_queue_drained", exp_cyc.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
